// File: rtl/johnson_pkg.sv
// johnson_pkg: shared state type and Johnson-code helpers used by the decoder and its classifier.
package johnson_pkg;

   typedef enum logic {SEARCH, LOCKED} state_t;

   localparam int JC_MAX_W = 32;

   // Legal codes are a run of ones anchored at bit0 (MSB clear) or at the MSB (MSB set).
   function automatic logic jc_legal(input logic [JC_MAX_W-1:0] code, input int w);
      int pc;
      logic [JC_MAX_W-1:0] mask, low, high;
      pc = $countones(code);
      mask = (JC_MAX_W'(1) << w) - JC_MAX_W'(1);
      low = (JC_MAX_W'(1) << pc) - JC_MAX_W'(1);
      high = mask & ~((JC_MAX_W'(1) << (w - pc)) - JC_MAX_W'(1));
      return ((code & ~mask) == '0) && (code[w-1] ? code == high : code == low);
   endfunction

   function automatic int jc_to_idx(input logic [JC_MAX_W-1:0] code, input int w);
      int pc;
      pc = $countones(code);
      return code[w-1] ? 2 * w - pc : pc;
   endfunction

   function automatic int jc_next(input int idx, input int w);
      return (idx + 1) % (2 * w);
   endfunction

   function automatic int jc_prev(input int idx, input int w);
      return (idx + 2 * w - 1) % (2 * w);
   endfunction

endpackage

// File: rtl/johnson_classify.sv
// johnson_classify: combinational legality check and index decode of one Johnson code.
module johnson_classify
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(2 * WIDTH)
)(
   input  logic [WIDTH-1:0] code_in,
   output logic             legal,
   output logic [IDX_W-1:0] idx
);

   assign legal = jc_legal(JC_MAX_W'(code_in), WIDTH);
   assign idx = IDX_W'(jc_to_idx(JC_MAX_W'(code_in), WIDTH));

endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: Johnson code decoder with lock/sequence monitor and saturating error count.
// Define JDEC_BIDIR_EN to also accept predecessor steps and expose the step direction on dir.
module johnson_decoder
   import johnson_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8,
   parameter int IDX_W    = $clog2(2 * WIDTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] code_in,
   input  logic             code_vld,
   input  logic             clr_err,
   output logic [IDX_W-1:0] idx,
   output logic             idx_vld,
   output logic             locked,
   output logic             illegal,
   output logic             seq_err,
`ifdef JDEC_BIDIR_EN
   output logic             dir,
`endif
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t           state, state_d;
   logic [3:0]       run, run_d;
   logic             has_ref, has_ref_d;
   logic [IDX_W-1:0] idx_d;
   logic             idx_vld_d, illegal_d, seq_err_d;
   logic [ERR_W-1:0] err_d;
   logic             legal;
   logic [IDX_W-1:0] cidx;
   logic             hold, succ, pred, step_ok;
`ifdef JDEC_BIDIR_EN
   logic             dir_d;
`endif

   johnson_classify #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_classify (
      .code_in (code_in),
      .legal   (legal),
      .idx     (cidx)
   );

   // has_ref keeps the first legal sample after reset from being judged against the reset idx.
   assign hold = has_ref && cidx == idx;
   assign succ = has_ref && cidx == IDX_W'(jc_next(int'(idx), WIDTH));
   assign pred = has_ref && cidx == IDX_W'(jc_prev(int'(idx), WIDTH));
`ifdef JDEC_BIDIR_EN
   assign step_ok = succ || pred;
`else
   assign step_ok = succ;
`endif
   assign locked = state == LOCKED;

   always_comb begin
      state_d = state;
      run_d = run;
      has_ref_d = has_ref;
      idx_d = idx;
      idx_vld_d = 1'b0;
      illegal_d = 1'b0;
      seq_err_d = 1'b0;
`ifdef JDEC_BIDIR_EN
      dir_d = dir;
`endif
      if (code_vld) begin
         if (!legal) begin
            illegal_d = 1'b1;
            run_d = '0;
            state_d = SEARCH;
         end else begin
            idx_vld_d = 1'b1;
            idx_d = cidx;
            has_ref_d = 1'b1;
`ifdef JDEC_BIDIR_EN
            if (step_ok && !hold) dir_d = succ;
`endif
            if (state == LOCKED) begin
               if (!(hold || step_ok)) begin
                  seq_err_d = 1'b1;
                  run_d = '0;
                  state_d = SEARCH;
               end
            end else begin
`ifdef JDEC_BIDIR_EN
               // A direction reversal restarts the run with this step as its first.
               if (!hold) run_d = !step_ok ? '0 : (run == '0 || dir == succ) ? run + 4'd1 : 4'd1;
`else
               if (!hold) run_d = step_ok ? run + 4'd1 : '0;
`endif
               if (run_d == 4'(LOCK_CNT)) state_d = LOCKED;
            end
         end
      end
      err_d = clr_err ? ((illegal_d || seq_err_d) ? ERR_W'(1) : '0) :
              ((illegal_d || seq_err_d) && err_cnt != ERR_MAX) ? err_cnt + ERR_W'(1) : err_cnt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= SEARCH;
         run <= '0;
         has_ref <= 1'b0;
         idx <= '0;
         idx_vld <= 1'b0;
         illegal <= 1'b0;
         seq_err <= 1'b0;
         err_cnt <= '0;
`ifdef JDEC_BIDIR_EN
         dir <= 1'b0;
`endif
      end else begin
         state <= state_d;
         run <= run_d;
         has_ref <= has_ref_d;
         idx <= idx_d;
         idx_vld <= idx_vld_d;
         illegal <= illegal_d;
         seq_err <= seq_err_d;
         err_cnt <= err_d;
`ifdef JDEC_BIDIR_EN
         dir <= dir_d;
`endif
      end
   end

endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
- Receive-side companion to the team's Johnson (twisted-ring) counter.
- Samples a WIDTH-bit Johnson code each valid cycle and decodes it to a binary state index.
- Flags illegal codes and sequence breaks, and tracks lock to a well-formed advancing sequence.
- Sits downstream of any Johnson counter output as a decoder plus protocol monitor.

Parameters:
- WIDTH, 4: Johnson code width; sequence length 2*WIDTH.
- LOCK_CNT, 3: consecutive valid successor steps required to enter LOCKED (1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- code_in  input  WIDTH  Johnson code sample.
- code_vld  input  1  code_in is sampled this cycle.
- clr_err  input  1  synchronous clear of err_cnt.
- idx  output  IDX_W=$clog2(2*WIDTH)  decoded index of the last legal sample.
- idx_vld  output  1  one-cycle pulse: idx updated from a legal sample.
- locked  output  1  monitor is in LOCKED.
- illegal  output  1  one-cycle pulse: the sampled code is not a Johnson code.
- seq_err  output  1  one-cycle pulse: a legal code that is not an allowed next step, while LOCKED.
- err_cnt  output  ERR_W  count of illegal and seq_err events, saturating.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset low asynchronously forces idx=0, idx_vld=0, locked=0, illegal=0, seq_err=0, err_cnt=0, run count=0, state=SEARCH.
  - Reset taking effect mid-sequence discards all history.
- Legal codes (WIDTH=4): 0000,0001,0011,0111,1111,1110,1100,1000, mapping to index 0..7.
  - MSB=0: code must be contiguous ones from bit0, and idx=popcount.
  - MSB=1: code must be contiguous ones from the MSB down, and idx=2*WIDTH-popcount (popcount=WIDTH gives WIDTH).
  - Any other pattern is illegal.
- Latency and pulses:
  - All outputs are registered; responses appear the cycle after the code_vld sample.
  - Pulses last exactly one cycle.
  - code_vld=0 produces no pulses and leaves state unchanged.
- Successor: next(i) = (i+1) mod 2*WIDTH, so wrap-around 7 to 0 is a legal step. "Hold" means same index as the previous legal sample.
- State SEARCH:
  - Legal sample: idx_vld=1.
    - If it is the successor of the previous index, run count +1; otherwise run count is reset to 0 and the reference is the new index.
    - When run count reaches LOCK_CNT: go to LOCKED, locked=1 from the next cycle.
    - Hold leaves the run count unchanged.
  - Illegal sample: illegal=1, err_cnt +1, run count=0.
- State LOCKED:
  - Legal successor or hold: idx_vld=1, stay in LOCKED.
  - Any other legal code: idx_vld=1, seq_err=1, err_cnt +1, go to SEARCH with run count=0 and reference = the new index.
  - Illegal code: illegal=1, err_cnt +1, idx unchanged, go to SEARCH.
- The first legal sample after reset only seeds the reference; it is never a seq_err.
- err_cnt:
  - Saturates at 2^ERR_W-1.
  - clr_err alone sets it to 0.
  - clr_err coinciding with an error event sets it to 1.
- illegal and seq_err are never both asserted in the same cycle.

Optional Feature:
- Macro JDEC_BIDIR_EN.
- Defined:
  - The predecessor step (i-1) mod 2*WIDTH is also legal.
  - Adds output dir (1 bit, reset 0): 1 = up, 0 = down. It updates on each non-hold legal step.
  - A step that reverses direction while LOCKED is accepted without error.
  - Lock counting accepts runs in a single consistent direction only.
- Undefined:
  - No dir port.
  - A predecessor step while LOCKED produces seq_err.

Decomposition:
- Package johnson_pkg holds:
  - state enum {SEARCH, LOCKED};
  - function jc_legal(code);
  - function jc_to_idx(code);
  - function jc_next(idx).
- One sub-module, johnson_classify: purely combinational; code_in in, legal and index out. It is reusable by the counter's own self-check.

Test Plan:
- Reset low, then high; drive 0000,0001,0011,0111 with code_vld=1 → idx 0,1,2,3; locked=1 the cycle after the 4th sample (LOCK_CNT=3); err_cnt=0.
- While locked, run the full loop 1000 then 0000 → idx 7 then 0, no seq_err, locked stays 1.
- While locked, drive 0101 → illegal=1 for one cycle, idx unchanged, err_cnt=1, locked=0 next cycle.
- While locked at idx 2, drive 1110 → idx=5, seq_err=1, err_cnt increments, state SEARCH; hold 0011 repeated while locked produces no error.
- Force 260 illegal samples with ERR_W=8 → err_cnt stays at 255; assert clr_err together with an illegal sample → err_cnt=1.
- Assert reset low mid-run at idx 4 → all outputs 0 asynchronously. With JDEC_BIDIR_EN defined, the locked sequence 3,2,1 gives dir=0 and no seq_err.
